mul7_acc: RTL and testbench

MUL7_ACC -- requirements
Module: mul7_acc

---
 rtl/mul7_pkg.sv | 18 +
 rtl/mul7_acc.sv | 111 +++++++++++
 tb/tb_mul7_acc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mul7_pkg.sv
// mul7_pkg -- shared defaults and FSM state encoding for the 7x7 product
// burst accumulator (mul7_acc).
//   DEF_PROD_W : width of an unsigned 7x7 product
//   DEF_CNT_W  : burst-length field width (bursts of 1..2^CNT_W beats)
//   DEF_ACC_W  : accumulator / result width, sized so a full burst cannot wrap
package mul7_pkg;

  localparam int DEF_PROD_W = 14;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_ACC_W  = DEF_PROD_W + DEF_CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mul7_state_t;

endpackage

// File: rtl/mul7_acc.sv
// mul7_acc -- accumulates a burst of 1..2^CNT_W unsigned products and
// presents the sum on a valid/ready output.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a burst (accepted in IDLE, or in DONE on handshake)
//   len        in   burst length minus one, latched on accepted start
//   abort      in   synchronous cancel; beats start, beats and handshake
//   prod_in    in   unsigned product from the upstream multiplier
//   prod_valid in   prod_in valid this cycle
//   prod_ready out  high in ACCUM
//   sum_out    out  burst result, held through DONE and afterwards
//   sum_valid  out  high in DONE
//   sum_ready  in   downstream accepts sum_out
//   busy       out  high in ACCUM or DONE
//
// All handshake outputs decode the registered state (Moore), so the result
// appears one cycle after the last beat.
module mul7_acc
  import mul7_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = PROD_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy
);

  mul7_state_t r_state, w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [ACC_W-1:0] r_sum;

  logic             w_beat;      // product accepted this cycle
  logic             w_last;      // accepted product closes the burst
  logic             w_hs;        // result taken by downstream
  logic             w_launch;    // a new burst begins next cycle
  logic [ACC_W-1:0] w_acc_add;

  assign w_beat    = (r_state == ST_ACCUM) && prod_valid;
  assign w_last    = w_beat && (r_cnt == r_len);
  assign w_hs      = (r_state == ST_DONE) && sum_ready;
  // start is only honoured from IDLE or on the DONE handshake (zero-bubble)
  assign w_launch  = start && ((r_state == ST_IDLE) || w_hs);
  // zero-extend the product; ACC_W leaves headroom for 2^CNT_W maximal beats
  assign w_acc_add = r_acc + {{(ACC_W-PROD_W){1'b0}}, prod_in};

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (start) w_state_nxt = ST_ACCUM;
        ST_ACCUM: if (w_last) w_state_nxt = ST_DONE;
        ST_DONE:  if (w_hs) w_state_nxt = start ? ST_ACCUM : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_sum <= '0;
    end else if (abort) begin
      // partial sum is dropped; r_sum keeps the last delivered result
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_launch) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= len;
    end else if (w_beat) begin
      r_acc <= w_acc_add;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_sum <= w_acc_add;
    end
  end

  // ---------------- Moore outputs ----------------
  assign prod_ready = (r_state == ST_ACCUM);
  assign sum_valid  = (r_state == ST_DONE);
  assign busy       = (r_state == ST_ACCUM) || (r_state == ST_DONE);
  assign sum_out    = r_sum;

endmodule

// File: tb/tb_mul7_acc.sv
module tb_mul7_acc;

  localparam int PROD_W = 14;
  localparam int CNT_W  = 4;
  localparam int ACC_W  = 18;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;

  int n_chk;
  int n_fail;

  mul7_acc u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [PROD_W-1:0] p);
    prod_in    = p;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic launch(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    start = 0; len = 0; abort = 0; prod_in = 0; prod_valid = 0; sum_ready = 0;
    rst_n = 0;
    #12;
    chk("rst_sum_out",   sum_out,    0);
    chk("rst_sum_valid", sum_valid,  0);
    chk("rst_ready",     prod_ready, 0);
    chk("rst_busy",      busy,       0);
    @(negedge clk); rst_n = 1;
    tick();
    chk("idle_ready", prod_ready, 0);
    chk("idle_busy",  busy,       0);

    // single beat, max product, result one cycle after the beat
    launch(4'd0);
    chk("b1_ready", prod_ready, 1);
    chk("b1_busy",  busy,       1);
    beat(14'd16129);
    chk("b1_valid", sum_valid,  1);
    chk("b1_sum",   sum_out,    16129);
    chk("b1_rdy_done", prod_ready, 0);
    sum_ready = 1; tick(); sum_ready = 0;
    chk("b1_idle_valid", sum_valid, 0);
    chk("b1_idle_busy",  busy,      0);
    chk("b1_hold_sum",   sum_out,   16129);

    // full-length burst of maximal products: no wrap
    launch(4'd15);
    for (int i = 0; i < 16; i++) begin
      chk("b16_nvalid", sum_valid, 0);
      beat(14'd16129);
    end
    chk("b16_valid", sum_valid, 1);
    chk("b16_sum",   sum_out,   258064);
    sum_ready = 1; tick(); sum_ready = 0;

    // stalled beats, with a stray start inside ACCUM
    launch(4'd3);
    for (int i = 1; i <= 4; i++) begin
      beat(PROD_W'(i));
      if (i < 4) begin
        for (int s = 0; s < 2; s++) begin
          chk("st_ready", prod_ready, 1);
          chk("st_nvalid", sum_valid, 0);
          if (i == 2 && s == 0) begin start = 1; len = 0; end
          tick();
          start = 0;
        end
      end
    end
    chk("st_valid", sum_valid, 1);
    chk("st_sum",   sum_out,   10);
    // back-pressure: result held stable, start ignored without handshake
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1; len = 7; end
      tick();
      start = 0;
      chk("bp_valid", sum_valid, 1);
      chk("bp_sum",   sum_out,   10);
    end
    // handshake + start: straight back to ACCUM
    sum_ready = 1; start = 1; len = 4'd1;
    tick();
    sum_ready = 0; start = 0;
    chk("zb_ready",  prod_ready, 1);
    chk("zb_nvalid", sum_valid,  0);
    beat(14'd5);
    chk("zb_mid_nvalid", sum_valid, 0);
    beat(14'd6);
    chk("zb_valid", sum_valid, 1);
    chk("zb_sum",   sum_out,   11);
    sum_ready = 1; tick(); sum_ready = 0;

    // abort mid-burst, wins over a concurrent beat
    launch(4'd3);
    beat(14'd100);
    beat(14'd200);
    abort = 1; prod_in = 14'd300; prod_valid = 1;
    tick();
    abort = 0; prod_valid = 0;
    chk("ab_busy",  busy,       0);
    chk("ab_ready", prod_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_nvalid", sum_valid, 0);
    end
    launch(4'd0);
    beat(14'd7);
    chk("ab_next_valid", sum_valid, 1);
    chk("ab_next_sum",   sum_out,   7);
    // abort beats handshake in DONE
    abort = 1; sum_ready = 1; start = 1;
    tick();
    abort = 0; sum_ready = 0; start = 0;
    chk("ab_done_busy", busy, 0);

    // asynchronous reset mid-ACCUM
    launch(4'd2);
    beat(14'd55);
    #2 rst_n = 0;
    #1;
    chk("ar_ready", prod_ready, 0);
    chk("ar_busy",  busy,       0);
    chk("ar_valid", sum_valid,  0);
    chk("ar_sum",   sum_out,    0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      prod_in = 14'd9; prod_valid = 1;
      tick();
      chk("ar_post_valid", sum_valid, 0);
      chk("ar_post_busy",  busy,      0);
    end
    prod_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
